half_array_sequencer: RTL and testbench
=======================================

Name: half_array_sequencer

Overview:
- Drives the row/column select and tag into the input array mux, and captures the filter's returned rows into the A/B/C half-sample arrays.
- Runs two passes. Horizontal pass: selects integer rows 0..NUM_PIXEL-1 and writes the filtered a/b/c rows into row-packed half arrays. Vertical pass: selects those half arrays back out, with the arrays frozen.
- Sits between the block controller (start/done) and the mux/filter datapath.

Parameters:
- NUM_PIXEL, 8, rows per half array and pixels per block edge.
- ROW_W, 120, bits per row (15 pixels x 8 bits).
- INT_COLS, 24, first half-A select code (NUM_PIXEL+7+1+NUM_PIXEL).
- IDLE_SEL, 255, select code driven when not issuing; the mux outputs zero for it.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a block.
- hold  in  1  downstream stall; freezes issue.
- sel  out  8  select code to the mux.
- s  out  8  tag to the mux; equals sel whenever sel_valid=1.
- sel_valid  out  1  sel/s is a live issue this cycle.
- res_valid  in  1  filter result valid.
- res_tag  in  8  tag returned with the result (mux so, delayed by the filter).
- res_a, res_b, res_c  in  ROW_W each  filtered quarter/half/three-quarter rows.
- a_half_array, b_half_array, c_half_array  out  NUM_PIXEL*ROW_W each  packed arrays; row k occupies [k*ROW_W +: ROW_W].
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at block end.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; sel=s=IDLE_SEL; sel_valid=0; busy=0; done=0.
  - All three arrays are zero; written_mask=0.
- States: IDLE, H_ISSUE, H_DRAIN, V_ISSUE, DONE.
- IDLE:
  - start=1 -> H_ISSUE and clear written_mask. Array contents are retained, not cleared.
  - Issue counter resets to 0. busy=1 from the next cycle.
- H_ISSUE:
  - Each cycle with hold=0: sel=s=counter, sel_valid=1, counter++.
  - After issuing NUM_PIXEL-1, go to H_DRAIN.
  - hold=1: sel/s keep their last value, sel_valid=0, counter frozen.
- Result capture (H_ISSUE and H_DRAIN only):
  - res_valid=1 with res_tag<NUM_PIXEL: write res_a/res_b/res_c into row res_tag of the respective arrays, registered, visible the next cycle. Set written_mask[res_tag].
  - A repeated tag overwrites the row; the mask bit stays set.
  - Tags >= NUM_PIXEL are ignored.
  - res_valid in any other state is ignored; arrays stay frozen.
- H_DRAIN:
  - sel=s=IDLE_SEL, sel_valid=0.
  - When written_mask is all ones, go to V_ISSUE on the next edge. A capture that completes the mask in the same cycle counts.
  - No timeout; waits indefinitely.
- V_ISSUE:
  - Counter restarts at 0. Each cycle with hold=0: sel=s=INT_COLS+counter, sel_valid=1.
  - Covers codes INT_COLS..INT_COLS+3*NUM_PIXEL-1 (24..47) in order. After the last code, go to DONE.
  - hold behaves as in H_ISSUE.
- DONE: done=1 for exactly one cycle; sel=IDLE_SEL, sel_valid=0, busy=0. Next state is IDLE.
- Latency: start at edge N gives sel=0 valid at edge N+1. H_ISSUE takes NUM_PIXEL cycles when hold=0.
- start while busy is ignored (no restart, no error).
- Reset mid-operation: immediate return to reset values, including array contents.
- Outputs sel, s, sel_valid, busy and done are all registered.

Test Plan:
- Reset, then start with hold=0 -> sel issues 0..7 on 8 consecutive cycles with sel_valid=1 and s=sel; sel=255 afterwards.
- Filter model returns res_a=row-index pattern (e.g. 120'h01..01 * (tag+1)) with tags 0..7 at 3-cycle latency -> a_half_array[k*120 +: 120] matches for all k; V_ISSUE starts exactly 1 cycle after the tag-7 capture.
- Tags returned out of order (7,3,0,...) including a duplicate tag 3 and a stray tag 9 -> arrays hold the last value per tag; tag 9 is dropped; V pass starts only once all 8 tags are seen.
- hold=1 for 4 cycles mid-H_ISSUE after sel=3 and mid-V_ISSUE after sel=30 -> no codes skipped or repeated; sel_valid=0 while held; V sequence is 24..47 contiguous, followed by a single-cycle done.
- start pulsed during H_DRAIN, plus res_valid during IDLE and V_ISSUE -> no restart, arrays unchanged.
- reset asserted during V_ISSUE at sel=35 -> sel=255, busy=0, arrays zero immediately; a fresh start runs a full block normally.

Source files
------------

// File: rtl/half_array_sequencer.sv
// ---------------------------------------------------------------------------
// half_array_sequencer
//
// Sequences one block through the input array mux and the sub-pel filter.
// Horizontal pass: issues integer rows 0..NUM_PIXEL-1 and captures the
// filtered a/b/c rows into three row-packed half arrays. Vertical pass:
// issues the half-array select codes back out while the arrays stay frozen.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   start          one-cycle pulse that begins a block (ignored while busy)
//   hold           downstream stall; freezes issue
//   sel, s         select code and tag to the mux (s always equals sel)
//   sel_valid      sel/s carries a live issue this cycle
//   res_valid      filter result valid
//   res_tag        tag returned with the filter result
//   res_a/b/c      filtered quarter/half/three-quarter rows
//   a/b/c_half_array  packed arrays, row k at [k*ROW_W +: ROW_W]
//   busy           high from the cycle after start is accepted until done
//   done           one-cycle pulse at block end
//
// State table
//   state       | meaning
//   ST_IDLE     | waiting for start
//   ST_H_ISSUE  | issuing integer rows 0..NUM_PIXEL-1
//   ST_H_DRAIN  | waiting for every row to come back from the filter
//   ST_V_ISSUE  | issuing half-array codes INT_COLS..INT_COLS+3*NUM_PIXEL-1
//   ST_DONE     | block finished; done pulses next cycle
// ---------------------------------------------------------------------------
module half_array_sequencer #(
    parameter int NUM_PIXEL = 8,
    parameter int ROW_W     = 120,
    parameter int INT_COLS  = 24,
    parameter int IDLE_SEL  = 255
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       hold,
    output logic [7:0]                 sel,
    output logic [7:0]                 s,
    output logic                       sel_valid,
    input  logic                       res_valid,
    input  logic [7:0]                 res_tag,
    input  logic [ROW_W-1:0]           res_a,
    input  logic [ROW_W-1:0]           res_b,
    input  logic [ROW_W-1:0]           res_c,
    output logic [NUM_PIXEL*ROW_W-1:0] a_half_array,
    output logic [NUM_PIXEL*ROW_W-1:0] b_half_array,
    output logic [NUM_PIXEL*ROW_W-1:0] c_half_array,
    output logic                       busy,
    output logic                       done
);

    localparam int V_CODES = 3 * NUM_PIXEL;
    localparam int CNT_W   = $clog2(V_CODES);
    localparam int IDX_W   = $clog2(NUM_PIXEL);
    localparam int ARR_W   = NUM_PIXEL * ROW_W;
    localparam logic [7:0] IDLE_CODE = 8'(IDLE_SEL);
    localparam logic [7:0] V_BASE    = 8'(INT_COLS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H_ISSUE,
        ST_H_DRAIN,
        ST_V_ISSUE,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           sel_q, sel_d;
    logic                 sel_valid_q, sel_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [NUM_PIXEL-1:0] mask_q, mask_d;
    logic [ARR_W-1:0]     a_q, a_d;
    logic [ARR_W-1:0]     b_q, b_d;
    logic [ARR_W-1:0]     c_q, c_d;

    logic                 capture;
    logic [IDX_W-1:0]     tag_idx;

    assign tag_idx = res_tag[IDX_W-1:0];

    // Results are only accepted while the horizontal pass is in flight so
    // the arrays stay stable for the vertical pass and between blocks.
    assign capture = res_valid && (res_tag < 8'(NUM_PIXEL)) &&
                     ((state_q == ST_H_ISSUE) || (state_q == ST_H_DRAIN));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        sel_valid_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mask_d      = mask_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;

        if (capture) begin
            a_d[int'(tag_idx)*ROW_W +: ROW_W] = res_a;
            b_d[int'(tag_idx)*ROW_W +: ROW_W] = res_b;
            c_d[int'(tag_idx)*ROW_W +: ROW_W] = res_c;
            mask_d[tag_idx]                   = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                sel_d  = IDLE_CODE;
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_H_ISSUE;
                    cnt_d   = '0;
                    mask_d  = '0;
                    busy_d  = 1'b1;
                end
            end

            ST_H_ISSUE: begin
                if (!hold) begin
                    sel_d       = 8'(cnt_q);
                    sel_valid_d = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NUM_PIXEL - 1)) begin
                        state_d = ST_H_DRAIN;
                    end
                end
            end

            ST_H_DRAIN: begin
                sel_d = IDLE_CODE;
                // mask_d already includes a capture landing this cycle.
                if (&mask_d) begin
                    state_d = ST_V_ISSUE;
                    cnt_d   = '0;
                end
            end

            ST_V_ISSUE: begin
                if (!hold) begin
                    sel_d       = V_BASE + 8'(cnt_q);
                    sel_valid_d = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(V_CODES - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                sel_d   = IDLE_CODE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                sel_d   = IDLE_CODE;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= IDLE_CODE;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mask_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mask_q      <= mask_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
        end
    end

    // The tag travels with the select code, so one register serves both.
    assign sel          = sel_q;
    assign s            = sel_q;
    assign sel_valid    = sel_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign a_half_array = a_q;
    assign b_half_array = b_q;
    assign c_half_array = c_q;

endmodule

// File: tb/tb_half_array_sequencer.sv
module tb_half_array_sequencer;

    localparam int NP = 8;
    localparam int RW = 120;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             hold = 1'b0;
    logic [7:0]       sel;
    logic [7:0]       s;
    logic             sel_valid;
    logic             res_valid = 1'b0;
    logic [7:0]       res_tag = 8'd0;
    logic [RW-1:0]    res_a = '0;
    logic [RW-1:0]    res_b = '0;
    logic [RW-1:0]    res_c = '0;
    logic [NP*RW-1:0] a_half_array;
    logic [NP*RW-1:0] b_half_array;
    logic [NP*RW-1:0] c_half_array;
    logic             busy;
    logic             done;

    half_array_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .hold         (hold),
        .sel          (sel),
        .s            (s),
        .sel_valid    (sel_valid),
        .res_valid    (res_valid),
        .res_tag      (res_tag),
        .res_a        (res_a),
        .res_b        (res_b),
        .res_c        (res_c),
        .a_half_array (a_half_array),
        .b_half_array (b_half_array),
        .c_half_array (c_half_array),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected array contents, maintained from what the bench itself drives.
    logic [RW-1:0] ea[NP];
    logic [RW-1:0] eb[NP];
    logic [RW-1:0] ec[NP];

    function automatic logic [RW-1:0] pat(int v);
        return {15{8'(v)}};
    endfunction

    function automatic void model_write(int tag, int v);
        if (tag < NP) begin
            ea[tag] = pat(v);
            eb[tag] = pat(v + 8'h40);
            ec[tag] = pat(v + 8'h80);
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NP; k++) begin
            ea[k] = '0;
            eb[k] = '0;
            ec[k] = '0;
        end
    endfunction

    task automatic check_arrays(string name);
        for (int k = 0; k < NP; k++) begin
            chk($sformatf("%s a[%0d]", name, k), a_half_array[k*RW +: RW], ea[k]);
            chk($sformatf("%s b[%0d]", name, k), b_half_array[k*RW +: RW], eb[k]);
            chk($sformatf("%s c[%0d]", name, k), c_half_array[k*RW +: RW], ec[k]);
        end
    endtask

    // Filter model: echoes each live issue back 3 cycles later.
    typedef struct {
        logic       v;
        logic [7:0] t;
    } pipe_t;

    pipe_t pipe[3];
    logic  auto_filt = 1'b0;
    int    pat_base = 0;

    function automatic void pipe_clear();
        for (int k = 0; k < 3; k++) pipe[k] = '{1'b0, 8'd0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        if (auto_filt) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{sel_valid, s};
            res_valid = pipe[2].v;
            res_tag   = pipe[2].t;
            res_a     = pat(pat_base + 1 + int'(pipe[2].t));
            res_b     = pat(pat_base + 1 + int'(pipe[2].t) + 8'h40);
            res_c     = pat(pat_base + 1 + int'(pipe[2].t) + 8'h80);
            if (pipe[2].v) model_write(int'(pipe[2].t), pat_base + 1 + int'(pipe[2].t));
        end
    endtask

    typedef struct {
        logic       start;
        logic       hold;
        logic [7:0] sel;
        logic       valid;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(logic st, logic hd, int sl, logic vl, logic bz, logic dn);
        vecs.push_back('{st, hd, 8'(sl), vl, bz, dn});
    endfunction

    function automatic void add_issue(int first, int n);
        for (int j = 0; j < n; j++) addv(1'b0, 1'b0, first + j, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic void add_block_plain();
        addv(1'b1, 1'b0, 255, 1'b0, 1'b1, 1'b0);
        add_issue(0, NP);
        for (int j = 0; j < 3; j++) addv(1'b0, 1'b0, 255, 1'b0, 1'b1, 1'b0);
        add_issue(24, 3 * NP);
        addv(1'b0, 1'b0, 255, 1'b0, 1'b0, 1'b1);
        addv(1'b0, 1'b0, 255, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic run_vecs(string name);
        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start;
            hold  = vecs[i].hold;
            tick();
            start = 1'b0;
            chk($sformatf("%s[%0d] sel", name, i), sel, vecs[i].sel);
            chk($sformatf("%s[%0d] s", name, i), s, vecs[i].sel);
            chk($sformatf("%s[%0d] sel_valid", name, i), sel_valid, vecs[i].valid);
            chk($sformatf("%s[%0d] busy", name, i), busy, vecs[i].busy);
            chk($sformatf("%s[%0d] done", name, i), done, vecs[i].done);
        end
        hold = 1'b0;
        vecs.delete();
    endtask

    typedef struct {
        int tag;
        int v;
    } res_t;

    task automatic drive_res(int tag, int v);
        res_valid = 1'b1;
        res_tag   = 8'(tag);
        res_a     = pat(v);
        res_b     = pat(v + 8'h40);
        res_c     = pat(v + 8'h80);
    endtask

    initial begin
        res_t rl[$];
        logic seen;

        model_clear();
        pipe_clear();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst sel", sel, 8'd255);
        chk("rst s", s, 8'd255);
        chk("rst sel_valid", sel_valid, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        check_arrays("rst");
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Plain block, 3-cycle filter; V pass begins one cycle after tag 7 lands
        auto_filt = 1'b1;
        pat_base  = 0;
        add_block_plain();
        run_vecs("t1");
        check_arrays("t1");

        // Out-of-order returns with duplicate and stray tags
        auto_filt = 1'b0;
        res_valid = 1'b0;
        addv(1'b1, 1'b0, 255, 1'b0, 1'b1, 1'b0);
        add_issue(0, NP);
        run_vecs("t2h");
        rl = '{'{7, 8'h27}, '{3, 8'h23}, '{0, 8'h20}, '{9, 8'h29}, '{3, 8'h33},
               '{1, 8'h21}, '{2, 8'h22}, '{4, 8'h24}, '{5, 8'h25}};
        foreach (rl[i]) begin
            drive_res(rl[i].tag, rl[i].v);
            model_write(rl[i].tag, rl[i].v);
            tick();
            chk($sformatf("t2 wait%0d sel", i), sel, 8'd255);
            chk($sformatf("t2 wait%0d valid", i), sel_valid, 1'b0);
        end
        res_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t2 idle%0d valid", i), sel_valid, 1'b0);
        end
        drive_res(6, 8'h26);
        model_write(6, 8'h26);
        tick();
        chk("t2 last sel", sel, 8'd255);
        res_valid = 1'b0;
        tick();
        chk("t2 vstart sel", sel, 8'd24);
        chk("t2 vstart valid", sel_valid, 1'b1);
        drive_res(2, 8'h3e);
        tick();
        res_valid = 1'b0;
        chk("t2 v1 sel", sel, 8'd25);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("t2 done seen", seen, 1'b1);
        drive_res(1, 8'h3d);
        tick();
        tick();
        res_valid = 1'b0;
        chk("t2 idle busy", busy, 1'b0);
        check_arrays("t2");

        // Hold in both passes; start during drain ignored
        pipe_clear();
        auto_filt = 1'b1;
        pat_base  = 8'h08;
        addv(1'b1, 1'b0, 255, 1'b0, 1'b1, 1'b0);
        add_issue(0, 4);
        for (int j = 0; j < 4; j++) addv(1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0);
        add_issue(4, 4);
        addv(1'b0, 1'b0, 255, 1'b0, 1'b1, 1'b0);
        addv(1'b1, 1'b0, 255, 1'b0, 1'b1, 1'b0);
        addv(1'b0, 1'b0, 255, 1'b0, 1'b1, 1'b0);
        add_issue(24, 7);
        for (int j = 0; j < 4; j++) addv(1'b0, 1'b1, 30, 1'b0, 1'b1, 1'b0);
        add_issue(31, 17);
        addv(1'b0, 1'b0, 255, 1'b0, 1'b0, 1'b1);
        addv(1'b0, 1'b0, 255, 1'b0, 1'b0, 1'b0);
        run_vecs("t3");
        check_arrays("t3");

        // Reset in the middle of the vertical pass, then a fresh block
        pipe_clear();
        pat_base = 8'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (sel_valid && sel == 8'd35) seen = 1'b1;
        end
        chk("t6 reached sel 35", seen, 1'b1);
        #2;
        reset = 1'b0;
        auto_filt = 1'b0;
        res_valid = 1'b0;
        pipe_clear();
        #1;
        chk("t6 rst sel", sel, 8'd255);
        chk("t6 rst sel_valid", sel_valid, 1'b0);
        chk("t6 rst busy", busy, 1'b0);
        chk("t6 rst done", done, 1'b0);
        model_clear();
        check_arrays("t6 rst");
        @(posedge clock);
        #1;
        reset = 1'b1;
        auto_filt = 1'b1;
        pat_base  = 0;
        add_block_plain();
        run_vecs("t6blk");
        check_arrays("t6blk");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
